// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the temperature-sensor target and the controller side:
// FSM state codes, LM75 address, bus bit encodings and synchroniser depth.
package i2c_pkg;

  localparam logic [6:0] LM75_ADDR       = 7'h48;
  localparam int         DEF_SYNC_STAGES = 2;

  localparam logic I2C_READ = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_TX_BYTE  = 3'd3;
  localparam logic [2:0] ST_M_ACK    = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  function automatic logic isReadOf(input logic [7:0] addrByte, input logic [6:0] devAddr);
    return (addrByte[7:1] == devAddr) && (addrByte[0] == I2C_READ);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and flags scl edges plus bus START/STOP.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_sclSync;
  logic [SYNC_STAGES-1:0] r_sdaSync;
  logic                   r_sclPrev;
  logic                   r_sdaPrev;
  logic                   w_sclS;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda};
      r_sclPrev <= w_sclS;
      r_sdaPrev <= sda_s;
    end
  end

  assign w_sclS    = r_sclSync[SYNC_STAGES-1];
  assign sda_s     = r_sdaSync[SYNC_STAGES-1];
  assign scl_rise  =  w_sclS & ~r_sclPrev;
  assign scl_fall  = ~w_sclS &  r_sclPrev;
  assign start_det =  w_sclS &  r_sclPrev &  r_sdaPrev & ~sda_s;
  assign stop_det  =  w_sclS &  r_sclPrev & ~r_sdaPrev &  sda_s;

endmodule

// File: rtl/i2c_temp_target.sv
// LM75-style I2C read target: ACKs its read address and streams a frozen 16-bit
// snapshot of temp_data MSB byte first, wrapping while the controller keeps ACKing.
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = LM75_ADDR,
  parameter int         SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_data,
  output logic        busy,
  output logic        rd_done
);

  logic [2:0]  r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitCnt;
  logic [15:0] r_shadow;
  logic        r_byteSel;
  logic        r_sdaLow;
  logic        r_ackSeen;
  logic        r_busy;
  logic        r_rdDone;

  logic        w_sclRise;
  logic        w_sclFall;
  logic        w_startDet;
  logic        w_stopDet;
  logic        w_sdaS;
  logic [7:0]  w_addrByte;
  logic [7:0]  w_curByte;
  logic [2:0]  w_nextIdx;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (w_sclRise),
    .scl_fall (w_sclFall),
    .start_det(w_startDet),
    .stop_det (w_stopDet),
    .sda_s    (w_sdaS)
  );

  assign w_addrByte = {r_shift[6:0], w_sdaS};
  assign w_curByte  = r_byteSel ? r_shadow[7:0] : r_shadow[15:8];
  assign w_nextIdx  = 3'd6 - r_bitCnt;

  // Bus conditions pre-empt whatever the current state would do in the same clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_shadow  <= '0;
      r_byteSel <= 1'b0;
      r_sdaLow  <= 1'b0;
      r_ackSeen <= 1'b0;
      r_busy    <= 1'b0;
      r_rdDone  <= 1'b0;
    end else begin
      r_rdDone <= 1'b0;
      if (w_stopDet) begin
        r_sdaLow  <= 1'b0;
        r_ackSeen <= 1'b0;
        r_busy    <= 1'b0;
        r_state   <= ST_IDLE;
      end else if (w_startDet) begin
        r_sdaLow  <= 1'b0;
        r_ackSeen <= 1'b0;
        r_bitCnt  <= '0;
        r_state   <= ST_ADDR;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_sclRise) begin
              r_shift  <= w_addrByte;
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                if (isReadOf(w_addrByte, DEV_ADDR)) begin
                  r_shadow  <= temp_data;
                  r_busy    <= 1'b1;
                  r_byteSel <= 1'b0;
                  r_state   <= ST_ADDR_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end
          // sda is released on entry, so its drive level doubles as the ACK phase flag.
          ST_ADDR_ACK: begin
            if (w_sclFall) begin
              if (!r_sdaLow) begin
                r_sdaLow <= 1'b1;
              end else begin
                r_sdaLow <= ~w_curByte[7];
                r_bitCnt <= '0;
                r_state  <= ST_TX_BYTE;
              end
            end
          end
          ST_TX_BYTE: begin
            if (w_sclFall) begin
              if (r_bitCnt == 3'd7) begin
                r_sdaLow <= 1'b0;
                r_state  <= ST_M_ACK;
              end else begin
                r_bitCnt <= r_bitCnt + 3'd1;
                r_sdaLow <= ~w_curByte[w_nextIdx];
              end
            end
          end
          ST_M_ACK: begin
            if (w_sclRise) begin
              if (w_sdaS == I2C_ACK) begin
                r_byteSel <= ~r_byteSel;
                r_ackSeen <= 1'b1;
              end else begin
                r_rdDone <= 1'b1;
                r_state  <= ST_IGNORE;
              end
            end else if (w_sclFall && r_ackSeen) begin
              r_ackSeen <= 1'b0;
              r_sdaLow  <= ~w_curByte[7];
              r_bitCnt  <= '0;
              r_state   <= ST_TX_BYTE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda     = r_sdaLow ? 1'b0 : 1'bz;
  assign busy    = r_busy;
  assign rd_done = r_rdDone;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Directed bench for i2c_temp_target: a behavioural I2C controller drives the bus
// and returned bytes are checked against a queue of expected values.
module tb_i2c_temp_target;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic        clk;
  logic        reset_n;
  logic        sclDrv;
  logic        sdaDrvLow;
  logic [15:0] temp_data;
  logic        busy;
  logic        rd_done;
  wire         sda;

  int          cmpCnt = 0;
  int          errCnt = 0;
  int          rdDoneCnt = 0;
  logic [7:0]  expQ[$];
  logic        ack;
  logic        bitVal;

  pullup (sda);
  assign sda = sdaDrvLow ? 1'b0 : 1'bz;

  i2c_temp_target dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (sclDrv),
    .sda      (sda),
    .temp_data(temp_data),
    .busy     (busy),
    .rd_done  (rd_done)
  );

  // 50 MHz system clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Counts every high cycle of rd_done, so a stretched pulse shows up as extra counts
  always @(negedge clk) begin
    if (rd_done) rdDoneCnt++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2cStart();
    sdaDrvLow = 1'b0;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q);
    sdaDrvLow = 1'b1;
    waitClk(Q);
    sclDrv = 1'b0;
    waitClk(Q);
  endtask

  // busy must survive two clks past the sda rise and be low after the third
  task automatic i2cStop(input logic busyBefore);
    sdaDrvLow = 1'b1;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q);
    sdaDrvLow = 1'b0;
    waitClk(2);
    checkOutput("stopBusyHold", 16'(busy), 16'(busyBefore));
    waitClk(1);
    checkOutput("stopBusyFall", 16'(busy), 16'd0);
    waitClk(Q);
  endtask

  task automatic writeBit(input logic b);
    sdaDrvLow = ~b;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(2 * Q);
    sclDrv = 1'b0;
    waitClk(Q);
  endtask

  task automatic readBit(output logic b);
    sdaDrvLow = 1'b0;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q);
    b = sda;
    waitClk(Q);
    sclDrv = 1'b0;
    waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] v, output logic ackOut);
    for (int i = 7; i >= 0; i--) writeBit(v[i]);
    readBit(ackOut);
  endtask

  task automatic readByte(input logic mAck, input string tag);
    logic [7:0] v;
    logic [7:0] exp;
    logic       b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      v = {v[6:0], b};
    end
    writeBit(mAck);
    if (expQ.size() == 0) begin
      cmpCnt++;
      errCnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=queue-entry", tag, v);
    end else begin
      exp = expQ.pop_front();
      checkOutput(tag, 16'(v), 16'(exp));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addrByte, output logic ackOut);
    i2cStart();
    writeByte(addrByte, ackOut);
  endtask

  initial begin
    reset_n   = 1'b0;
    sclDrv    = 1'b1;
    sdaDrvLow = 1'b0;
    temp_data = 16'h1A80;
    ack       = 1'b1;
    bitVal    = 1'b1;
    waitClk(3);
    checkOutput("rstBusy", 16'(busy), 16'd0);
    checkOutput("rstRdDone", 16'(rd_done), 16'd0);
    checkOutput("rstSda", 16'(sda), 16'd1);
    reset_n = 1'b1;
    waitClk(5);

    $display("[TB] nominal read");
    applyStimulus(8'h91, ack);
    checkOutput("nomAddrAck", 16'(ack), 16'(I2C_ACK));
    checkOutput("nomBusy", 16'(busy), 16'd1);
    expQ.push_back(8'h1A);
    expQ.push_back(8'h80);
    readByte(I2C_ACK, "nomByte1");
    readByte(I2C_NACK, "nomByte2");
    checkOutput("nomRdDone", rdDoneCnt[15:0], 16'd1);
    i2cStop(1'b1);

    $display("[TB] wrong address and write request");
    applyStimulus(8'h93, ack);
    checkOutput("badAddrAck", 16'(ack), 16'(I2C_NACK));
    checkOutput("badAddrBusy", 16'(busy), 16'd0);
    i2cStop(1'b0);
    applyStimulus(8'h90, ack);
    checkOutput("writeAck", 16'(ack), 16'(I2C_NACK));
    checkOutput("writeBusy", 16'(busy), 16'd0);
    i2cStop(1'b0);
    checkOutput("badRdDone", rdDoneCnt[15:0], 16'd1);

    $display("[TB] shadow hold");
    temp_data = 16'h1A80;
    applyStimulus(8'h91, ack);
    checkOutput("shadowAck", 16'(ack), 16'(I2C_ACK));
    temp_data = 16'hFFFF;
    expQ.push_back(8'h1A);
    expQ.push_back(8'h80);
    readByte(I2C_ACK, "shadowByte1");
    readByte(I2C_NACK, "shadowByte2");
    checkOutput("shadowRdDone", rdDoneCnt[15:0], 16'd2);
    i2cStop(1'b1);

    $display("[TB] wrap after byte 2");
    temp_data = 16'h1A80;
    applyStimulus(8'h91, ack);
    checkOutput("wrapAck", 16'(ack), 16'(I2C_ACK));
    expQ.push_back(8'h1A);
    expQ.push_back(8'h80);
    expQ.push_back(8'h1A);
    readByte(I2C_ACK, "wrapByte1");
    readByte(I2C_ACK, "wrapByte2");
    readByte(I2C_NACK, "wrapByte3");
    checkOutput("wrapRdDone", rdDoneCnt[15:0], 16'd3);
    i2cStop(1'b1);

    $display("[TB] repeated START");
    temp_data = 16'h1A80;
    applyStimulus(8'h91, ack);
    checkOutput("rsAck1", 16'(ack), 16'(I2C_ACK));
    expQ.push_back(8'h1A);
    readByte(I2C_NACK, "rsFirstByte");
    checkOutput("rsRdDone1", rdDoneCnt[15:0], 16'd4);
    temp_data = 16'h3C55;
    applyStimulus(8'h91, ack);
    checkOutput("rsAck2", 16'(ack), 16'(I2C_ACK));
    checkOutput("rsBusy", 16'(busy), 16'd1);
    expQ.push_back(8'h3C);
    expQ.push_back(8'h55);
    readByte(I2C_ACK, "rsByte1");
    readByte(I2C_NACK, "rsByte2");
    checkOutput("rsRdDone2", rdDoneCnt[15:0], 16'd5);
    i2cStop(1'b1);

    $display("[TB] reset while driving sda low");
    temp_data = 16'h0000;
    applyStimulus(8'h91, ack);
    checkOutput("midAck", 16'(ack), 16'(I2C_ACK));
    for (int i = 0; i < 3; i++) begin
      readBit(bitVal);
      checkOutput("midBit", 16'(bitVal), 16'd0);
    end
    checkOutput("midSdaLow", 16'(sda), 16'd0);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midRstSda", 16'(sda), 16'd1);
    checkOutput("midRstBusy", 16'(busy), 16'd0);
    checkOutput("midRstRdDone", 16'(rd_done), 16'd0);
    waitClk(2);
    reset_n = 1'b1;
    waitClk(5);
    writeByte(8'h91, ack);
    checkOutput("postRstNoStartAck", 16'(ack), 16'(I2C_NACK));
    checkOutput("postRstNoStartBusy", 16'(busy), 16'd0);
    i2cStop(1'b0);
    temp_data = 16'hA5C3;
    applyStimulus(8'h91, ack);
    checkOutput("postRstAck", 16'(ack), 16'(I2C_ACK));
    expQ.push_back(8'hA5);
    expQ.push_back(8'hC3);
    readByte(I2C_ACK, "postRstByte1");
    readByte(I2C_NACK, "postRstByte2");
    checkOutput("postRstRdDone", rdDoneCnt[15:0], 16'd6);
    i2cStop(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
